// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Used by fetch_unit, fetch_fsm and the control unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } fstate_t;

  localparam logic [1:0] PCSEL_ALU    = 2'b00;
  localparam logic [1:0] PCSEL_ALUOUT = 2'b01;
  localparam logic [1:0] PCSEL_JUMP   = 2'b10;
  localparam logic [1:0] PCSEL_HOLD   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [31:0] jump_target(
    input logic [31:0] pc,
    input logic [31:0] ir
  );
    return {pc[31:28], ir[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencer: issues one imem read per request,
// loads IR on ack or a nop on timeout.
module fetch_fsm
  import fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IRWE,
  input  logic [31:0] PC,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IR,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  fstate_t       state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      IR         <= '0;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (IRWE) begin
            imem_addr  <= PC;
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
            wait_cnt   <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          // ack wins even in the last allowed cycle
          if (imem_ack) begin
            IR         <= imem_rdata;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            state      <= S_DONE;
          end else if (wait_cnt == LAST) begin
            IR         <= '0;
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            state      <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          state      <= S_IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, ALUOut and next-PC mux,
// with the memory handshake delegated to fetch_fsm.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IRWE,
  input  logic        PCWE,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [1:0]  PCSel,
  input  logic [31:0] ALUResult,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  opcode,
  output logic [31:0] ALUOut,
  output logic        fetch_busy,
  output logic        fetch_err
);

  logic        pc_en;
  logic [31:0] next_pc;

  fetch_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .CLK       (CLK),
    .RST       (RST),
    .IRWE      (IRWE),
    .PC        (PC),
    .imem_rdata(imem_rdata),
    .imem_ack  (imem_ack),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .IR        (IR),
    .fetch_busy(fetch_busy),
    .fetch_err (fetch_err)
  );

  assign opcode = IR[31:26];
  assign pc_en  = PCWE | (Branch & Zero);

  always_comb begin
    next_pc = PC;
    unique case (PCSel)
      PCSEL_ALU:    next_pc = ALUResult;
      PCSEL_ALUOUT: next_pc = ALUOut;
      PCSEL_JUMP:   next_pc = jump_target(PC, IR);
      PCSEL_HOLD:   next_pc = PC;
      default:      next_pc = PC;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC     <= RESET_PC;
      ALUOut <= '0;
    end else begin
      ALUOut <= ALUResult;
      if (pc_en) PC <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus
// randomized fetches and PC updates against a reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IRWE, PCWE, Branch, Zero, imem_ack;
  logic [1:0]  PCSel;
  logic [31:0] ALUResult, imem_rdata;
  logic        imem_req, fetch_busy, fetch_err;
  logic [31:0] imem_addr, PC, IR, ALUOut;
  logic [5:0]  opcode;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .TIMEOUT (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IRWE      (IRWE),
    .PCWE      (PCWE),
    .Branch    (Branch),
    .Zero      (Zero),
    .PCSel     (PCSel),
    .ALUResult (ALUResult),
    .imem_rdata(imem_rdata),
    .imem_ack  (imem_ack),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .PC        (PC),
    .IR        (IR),
    .opcode    (opcode),
    .ALUOut    (ALUOut),
    .fetch_busy(fetch_busy),
    .fetch_err (fetch_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic        err;
    int          busy;
  } fexp_t;

  fexp_t       fq[$];
  logic [31:0] pq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] pc_m, aluout_m, ir_m;
  logic        err_m;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pc_m     = RST_PC;
    aluout_m = ALUResult;
    ir_m     = '0;
    err_m    = 1'b0;
  endtask

  // next PC for the inputs currently driven, pushed for the monitor
  task automatic model_edge();
    logic [31:0] n;
    n = pc_m;
    if ((PCWE || (Branch && Zero)) && PCSel != 2'b11) begin
      case (PCSel)
        2'b00:   n = ALUResult;
        2'b01:   n = aluout_m;
        default: n = {pc_m[31:28], ir_m[25:0], 2'b00};
      endcase
    end
    pq.push_back(n);
    pc_m     = n;
    aluout_m = ALUResult;
  endtask

  task automatic step_pc(input logic we, input logic br, input logic z,
                         input logic [1:0] sel, input logic [31:0] alur);
    IRWE      = 1'b0;
    PCWE      = we;
    Branch    = br;
    Zero      = z;
    PCSel     = sel;
    ALUResult = alur;
    model_edge();
    @(negedge CLK);
  endtask

  // one fetch; dly = REQ cycles without ack before the ack cycle
  task automatic do_fetch(input int dly, input logic [31:0] data,
                          input bit pcw, input logic [31:0] pcv);
    fexp_t e;
    bit    tmo;
    tmo    = (dly >= TMO);
    e.addr = pc_m;
    e.ir   = tmo ? 32'h0 : data;
    err_m  = err_m | tmo;
    e.err  = err_m;
    e.busy = tmo ? TMO : dly + 1;
    fq.push_back(e);
    IRWE   = 1'b1;
    Branch = 1'b0;
    PCWE   = pcw;
    if (pcw) begin
      PCSel     = PCSEL_ALU;
      ALUResult = pcv;
    end
    model_edge();
    @(negedge CLK);
    IRWE = 1'b0;
    PCWE = 1'b0;
    if (!tmo) begin
      repeat (dly) begin
        imem_rdata = $urandom;
        @(negedge CLK);
        IRWE = 1'($urandom % 2);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge CLK);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      IRWE       = 1'($urandom % 2);
    end else begin
      repeat (TMO) begin
        @(negedge CLK);
        IRWE = 1'($urandom % 2);
      end
      // late ack arrives in DONE and must be ignored
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
    end
    @(negedge CLK);
    imem_ack = 1'b0;
    IRWE     = 1'b0;
    ir_m     = e.ir;
  endtask

  // monitor: pops expected PC each cycle, fetch result on busy fall
  initial begin
    int    busy_n;
    logic  pb;
    fexp_t e;
    busy_n = 0;
    pb     = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        pb     = 1'b0;
        busy_n = 0;
      end else begin
        if (pq.size() > 0) chk("pc", PC, pq.pop_front());
        if (fetch_busy) begin
          busy_n++;
          chk("req_eq_busy", 32'(imem_req), 32'd1);
        end else if (pb) begin
          if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: got ir %h expected none", IR);
          end else begin
            e = fq.pop_front();
            chk("f_addr", imem_addr, e.addr);
            chk("f_ir", IR, e.ir);
            chk("f_op", 32'(opcode), 32'(e.ir[31:26]));
            chk("f_err", 32'(fetch_err), 32'(e.err));
            chk("f_busy", 32'(busy_n), 32'(e.busy));
          end
          busy_n = 0;
        end
        pb = fetch_busy;
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    RST        = 1'b1;
    IRWE       = 1'b0;
    PCWE       = 1'b0;
    Branch     = 1'b0;
    Zero       = 1'b0;
    PCSel      = PCSEL_HOLD;
    ALUResult  = '0;
    imem_rdata = '0;
    imem_ack   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_pc", PC, RST_PC);
    chk("rst_ir", IR, 32'h0);
    chk("rst_aluout", ALUOut, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    RST = 1'b0;
    model_reset();

    // fetch with PC write in the same cycle, ack in 2nd REQ cycle
    do_fetch(1, 32'h8C01_0004, 1'b1, 32'h4);
    chk("d_ir", IR, 32'h8C01_0004);
    chk("d_opcode", 32'(opcode), 32'(6'b100011));
    chk("d_addr", imem_addr, 32'h0);
    chk("d_pc", PC, 32'h4);

    // branch not taken, then taken via ALUOut
    step_pc(1'b0, 1'b1, 1'b0, PCSEL_ALUOUT, 32'h40);
    chk("br_nt", PC, 32'h4);
    step_pc(1'b0, 1'b1, 1'b1, PCSEL_ALUOUT, 32'h0);
    chk("br_t", PC, 32'h40);
    chk("aluout", ALUOut, 32'h0);

    // jump target
    do_fetch(0, 32'h0800_0003, 1'b0, 32'h0);
    step_pc(1'b1, 1'b0, 1'b0, PCSEL_ALU, 32'hF000_0010);
    step_pc(1'b1, 1'b0, 1'b0, PCSEL_JUMP, 32'h0);
    chk("jump", PC, 32'hF000_000C);
    step_pc(1'b1, 1'b0, 1'b0, PCSEL_HOLD, 32'h1234_5678);
    chk("hold", PC, 32'hF000_000C);

    // timeout, then sticky error across a good fetch
    do_fetch(TMO, 32'hAAAA_5555, 1'b0, 32'h0);
    chk("tmo_ir", IR, 32'h0);
    chk("tmo_err", 32'(fetch_err), 32'd1);
    do_fetch(3, 32'h2001_0007, 1'b1, 32'h100);
    chk("sticky_err", 32'(fetch_err), 32'd1);
    chk("post_tmo_ir", IR, 32'h2001_0007);

    // reset in the middle of a fetch
    IRWE = 1'b1;
    @(negedge CLK);
    IRWE = 1'b0;
    chk("mid_req", 32'(imem_req), 32'd1);
    RST = 1'b1;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_busy", 32'(fetch_busy), 32'd0);
    chk("mid_rst_pc", PC, RST_PC);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    imem_ack = 1'b0;
    chk("late_ack_ir", IR, 32'h0);
    chk("rst_err_clr", 32'(fetch_err), 32'd0);
    @(negedge CLK);

    // randomized traffic
    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        a = $urandom;
        step_pc(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                2'($urandom % 4), a);
      end
      a = $urandom;
      a[1:0] = 2'b00;
      d = $urandom;
      do_fetch(int'($urandom_range(0, TMO + 3)), d, 1'($urandom % 2), a);
    end

    repeat (3) @(negedge CLK);
    chk("fq_drained", 32'(fq.size()), 32'd0);
    chk("pq_drained", 32'(pq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 16, maximum cycles waited for imem_ack before abandoning a fetch.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 IRWE  input  1  fetch request from the control unit.
REQ-006 PCWE  input  1  unconditional PC write enable.
REQ-007 Branch  input  1  conditional PC write enable, qualified by Zero.
REQ-008 Zero  input  1  ALU zero flag.
REQ-009 PCSel  input  2  next-PC source: 00 ALUResult, 01 ALUOut, 10 jump target, 11 hold.
REQ-010 ALUResult  input  32  combinational ALU output.
REQ-011 imem_rdata  input  32  instruction memory read data, valid when imem_ack=1.
REQ-012 imem_ack  input  1  instruction memory completion strobe.
REQ-013 imem_req  output  1  instruction memory read request.
REQ-014 imem_addr  output  32  instruction memory address, stable while imem_req=1.
REQ-015 PC  output  32  program counter.
REQ-016 IR  output  32  instruction register.
REQ-017 opcode  output  6  IR[31:26], driven to the control unit.
REQ-018 ALUOut  output  32  registered ALUResult (branch-target hold).
REQ-019 fetch_busy  output  1  high while a fetch is outstanding.
REQ-020 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-021 FSM states: IDLE, REQ, DONE; encoding lives in the shared package.
REQ-022 IDLE: IRWE=1 -> latch imem_addr<=PC, go to REQ; IRWE=0 -> stay.
REQ-023 REQ: imem_req=1, fetch_busy=1; imem_ack=1 -> IR<=imem_rdata, go to DONE.
REQ-024 REQ: wait counter increments each cycle without ack; on reaching TIMEOUT -> IR<=32'h0 (nop), fetch_err<=1, go to DONE.
REQ-025 DONE lasts exactly one cycle, imem_req=0, then goes to IDLE; minimum fetch latency is 3 cycles from IRWE to IDLE (ack in first REQ cycle).
REQ-026 IRWE asserted in REQ or DONE is ignored; no queuing.
REQ-027 imem_ack outside REQ is ignored; IR is unchanged.
REQ-028 pc_en = PCWE | (Branch & Zero); when pc_en=1 and PCSel!=11, PC loads the selected source on the next edge.
REQ-029 Jump target = {PC[31:28], IR[25:0], 2'b00}, computed from the current PC and IR.
REQ-030 PC updates are independent of the fetch FSM; a PC write during REQ does not alter imem_addr.
REQ-031 ALUOut <= ALUResult every cycle, unconditionally.
REQ-032 All arithmetic is 32-bit unsigned, wrapping modulo 2^32.
REQ-033 fetch_err clears only on reset.

Reset
REQ-034 RST=1 forces immediately: FSM=IDLE, PC=RESET_PC, IR=0, ALUOut=0, imem_addr=0, wait counter=0, imem_req=0, fetch_busy=0, fetch_err=0.
REQ-035 RST mid-fetch abandons the request; a later imem_ack for it is ignored under REQ-027.

Structure
REQ-036 The shared package holds the FSM state typedef, the PCSel codes (PCSEL_ALU, PCSEL_ALUOUT, PCSEL_JUMP, PCSEL_HOLD) and the opcode constants shared with the control unit.
REQ-037 One sub-module, fetch_fsm, contains the FSM, wait counter and IR load; PC, ALUOut and next-PC mux stay in fetch_unit.

Verification
REQ-038 Reset, then IRWE=1 for 1 cycle, ack after 2 cycles with rdata=32'h8C01_0004 -> imem_addr=0, IR=32'h8C01_0004, opcode=6'b100011, fetch_busy high for exactly 2 cycles.
REQ-039 PCWE=1, PCSel=00, ALUResult=32'h4 issued together with IRWE -> PC=4 next cycle, imem_addr stays 0 throughout REQ.
REQ-040 Branch=1, Zero=0, PCSel=01 -> PC unchanged; Branch=1, Zero=1, ALUOut=32'h40 -> PC=32'h40.
REQ-041 PC=32'hF000_0010, IR=32'h0800_0003, PCWE=1, PCSel=10 -> PC=32'hF000_000C.
REQ-042 No ack for 16 cycles -> IR=0, fetch_err=1 and sticky; a late ack is ignored; RST asserted mid-REQ -> imem_req drops the same cycle, PC=RESET_PC.
